// File: rtl/apb_slave_regbank_if.sv
// APB completer-side bus bundle for apb_slave_regbank.
// Requester drives select/strobe/address/data; completer returns ready/data/error.
interface apb_slave_regbank_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) ();
  logic                  pselx;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output pselx, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  pselx, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_slave_regbank.sv
// APB completer with a small read/write register bank, programmable wait states
// and an error response for addresses outside the implemented bank.
module apb_slave_regbank #(
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_REGS    = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  apb_slave_regbank_if.slave  bus
);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  // One extra bit so NUM_REGS == 2**ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0] NUM_REGS_L = (ADDR_WIDTH + 1)'(NUM_REGS);
  localparam logic [3:0]          WAIT_L     = 4'(WAIT_CYCLES);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  logic                  setup_s;
  logic                  done_s;
  logic                  in_range_s;
  logic [DATA_WIDTH-1:0] rd_s;

  assign setup_s    = bus.pselx && !bus.penable;
  assign in_range_s = {1'b0, addr_q} < NUM_REGS_L;

  // Transfer FSM: setup latches the request, access counts down the wait states.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    done_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (setup_s) begin
          addr_d  = bus.paddr;
          wdata_d = bus.pwdata;
          write_d = bus.pwrite;
          cnt_d   = WAIT_L;
          state_d = S_ACCESS;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (!bus.pselx) begin
          state_d = S_IDLE;
        end else if (!bus.penable) begin
          // A fresh setup mid-transfer replaces the pending request.
          addr_d  = bus.paddr;
          wdata_d = bus.pwdata;
          write_d = bus.pwrite;
          cnt_d   = WAIT_L;
          state_d = S_ACCESS;
        end else if (cnt_q != 4'd0) begin
          cnt_d   = cnt_q - 4'd1;
          state_d = S_ACCESS;
        end else begin
          done_s  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Register bank read mux and completion-time write.
  always_comb begin
    rd_s   = '0;
    regs_d = regs_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr_q == ADDR_WIDTH'(i)) begin
        rd_s = regs_q[i];
        if (done_s && write_q) begin
          regs_d[i] = wdata_q;
        end else begin
          regs_d[i] = regs_q[i];
        end
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // State, request latches and register bank storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign bus.pready  = done_s;
  assign bus.prdata  = (done_s && in_range_s && !write_q) ? rd_s : '0;
  assign bus.pslverr = done_s && !in_range_s;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Directed bench for apb_slave_regbank: three instances with 1, 0 and 3 wait
// states share one stimulus bus, selected by index, and a table of transfers.
module tb_apb_slave_regbank;

  logic       clk = 1'b0;
  logic       rst;
  logic       psel, pen, pwr;
  logic [3:0] paddr;
  logic [7:0] pwd;
  int         sel;

  logic       pready_m;
  logic [7:0] prdata_m;
  logic       pslverr_m;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  apb_slave_regbank_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus0 ();
  apb_slave_regbank_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus1 ();
  apb_slave_regbank_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus2 ();

  assign bus0.pselx = psel && (sel == 0);
  assign bus1.pselx = psel && (sel == 1);
  assign bus2.pselx = psel && (sel == 2);
  assign bus0.penable = pen;  assign bus1.penable = pen;  assign bus2.penable = pen;
  assign bus0.pwrite  = pwr;  assign bus1.pwrite  = pwr;  assign bus2.pwrite  = pwr;
  assign bus0.paddr   = paddr; assign bus1.paddr  = paddr; assign bus2.paddr  = paddr;
  assign bus0.pwdata  = pwd;  assign bus1.pwdata  = pwd;  assign bus2.pwdata  = pwd;

  apb_slave_regbank #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .NUM_REGS(8), .WAIT_CYCLES(1))
    u_dut_w1 (.clk(clk), .rst(rst), .bus(bus0));
  apb_slave_regbank #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .NUM_REGS(8), .WAIT_CYCLES(0))
    u_dut_w0 (.clk(clk), .rst(rst), .bus(bus1));
  apb_slave_regbank #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .NUM_REGS(8), .WAIT_CYCLES(3))
    u_dut_w3 (.clk(clk), .rst(rst), .bus(bus2));

  always_comb begin
    case (sel)
      0:       begin pready_m = bus0.pready; prdata_m = bus0.prdata; pslverr_m = bus0.pslverr; end
      1:       begin pready_m = bus1.pready; prdata_m = bus1.prdata; pslverr_m = bus1.pslverr; end
      default: begin pready_m = bus2.pready; prdata_m = bus2.prdata; pslverr_m = bus2.pslverr; end
    endcase
  end

  typedef struct {
    int         dut;
    logic       wr;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
    logic       exp_err;
  } vec_t;

  vec_t vecs [15];

  function automatic int wait_of(input int d);
    case (d)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Setup then access; address/data are scrambled during access to prove latching.
  task automatic xfer(input int d, input logic wr, input logic [3:0] a, input logic [7:0] wd,
                      output logic [7:0] rd, output logic err, output int lat);
    @(negedge clk);
    sel = d; psel = 1'b1; pen = 1'b0; pwr = wr; paddr = a; pwd = wd;
    @(negedge clk);
    pen = 1'b1; paddr = ~a; pwd = ~wd;
    #1;
    lat = 0;
    while (!pready_m && lat < 20) begin
      @(negedge clk);
      #1;
      lat++;
    end
    rd  = prdata_m;
    err = pslverr_m;
  endtask

  task automatic go_idle();
    @(negedge clk);
    psel = 1'b0; pen = 1'b0;
  endtask

  task automatic check_read(input string name, input int d, input logic [3:0] a,
                            input logic [7:0] exp);
    logic [7:0] rd;
    logic       err;
    int         lat;
    xfer(d, 1'b0, a, 8'h00, rd, err, lat);
    chk({name, "_lat"}, lat, wait_of(d));
    chk({name, "_rd"}, rd, exp);
    chk({name, "_err"}, err, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd;
    logic       err;
    int         lat;

    vecs[0]  = '{0, 1'b1, 4'd3,  8'hA5, 8'h00, 1'b0};
    vecs[1]  = '{0, 1'b0, 4'd3,  8'h00, 8'hA5, 1'b0};
    vecs[2]  = '{1, 1'b1, 4'd1,  8'h11, 8'h00, 1'b0};
    vecs[3]  = '{1, 1'b1, 4'd2,  8'h22, 8'h00, 1'b0};
    vecs[4]  = '{1, 1'b0, 4'd1,  8'h00, 8'h11, 1'b0};
    vecs[5]  = '{1, 1'b0, 4'd2,  8'h00, 8'h22, 1'b0};
    vecs[6]  = '{0, 1'b1, 4'd9,  8'hFF, 8'h00, 1'b1};
    vecs[7]  = '{0, 1'b0, 4'd15, 8'h00, 8'h00, 1'b1};
    vecs[8]  = '{0, 1'b0, 4'd1,  8'h00, 8'h00, 1'b0};
    vecs[9]  = '{0, 1'b0, 4'd3,  8'h00, 8'hA5, 1'b0};
    vecs[10] = '{0, 1'b1, 4'd7,  8'h5A, 8'h00, 1'b0};
    vecs[11] = '{0, 1'b0, 4'd7,  8'h00, 8'h5A, 1'b0};
    vecs[12] = '{2, 1'b1, 4'd6,  8'hC3, 8'h00, 1'b0};
    vecs[13] = '{2, 1'b0, 4'd6,  8'h00, 8'hC3, 1'b0};
    vecs[14] = '{1, 1'b0, 4'd3,  8'h00, 8'h00, 1'b0};

    // Reset held with select asserted.
    rst = 1'b0; sel = 0; psel = 1'b1; pen = 1'b0; pwr = 1'b1; paddr = 4'd3; pwd = 8'hEE;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_pready0", bus0.pready, 1'b0);
    chk("rst_pready1", bus1.pready, 1'b0);
    chk("rst_pready2", bus2.pready, 1'b0);
    chk("rst_prdata0", bus0.prdata, 8'h00);
    chk("rst_pslverr0", bus0.pslverr, 1'b0);
    psel = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    for (int a = 0; a < 8; a++) begin
      check_read($sformatf("rst_read%0d", a), 0, 4'(a), 8'h00);
    end

    for (int i = 0; i < 15; i++) begin
      xfer(vecs[i].dut, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, err, lat);
      chk($sformatf("vec%0d_lat", i), lat, wait_of(vecs[i].dut));
      chk($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
    end

    // Abort: drop select during the wait state.
    @(negedge clk);
    sel = 0; psel = 1'b1; pen = 1'b0; pwr = 1'b1; paddr = 4'd4; pwd = 8'h3C;
    @(negedge clk);
    pen = 1'b1;
    #1 chk("abort_wait_pready", pready_m, 1'b0);
    @(negedge clk);
    psel = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 chk($sformatf("abort_idle%0d_pready", k), bus0.pready, 1'b0);
    end
    check_read("abort_reg4", 0, 4'd4, 8'h00);

    // Re-setup during ACCESS replaces the pending write.
    @(negedge clk);
    sel = 0; psel = 1'b1; pen = 1'b0; pwr = 1'b1; paddr = 4'd2; pwd = 8'h99;
    @(negedge clk);
    paddr = 4'd6; pwd = 8'h44;
    #1 chk("resetup_pready_a", pready_m, 1'b0);
    @(negedge clk);
    pen = 1'b1; paddr = 4'd0; pwd = 8'h00;
    #1 chk("resetup_pready_b", pready_m, 1'b0);
    @(negedge clk);
    #1 chk("resetup_pready_c", pready_m, 1'b1);
    check_read("resetup_reg2", 0, 4'd2, 8'h00);
    check_read("resetup_reg6", 0, 4'd6, 8'h44);

    // Reset in the second wait cycle of a write on the 3-wait instance.
    @(negedge clk);
    sel = 2; psel = 1'b1; pen = 1'b0; pwr = 1'b1; paddr = 4'd5; pwd = 8'h77;
    @(negedge clk);
    pen = 1'b1;
    @(negedge clk);
    #1 chk("midrst_wait_pready", pready_m, 1'b0);
    #1 rst = 1'b0;
    #1;
    chk("midrst_pready", bus2.pready, 1'b0);
    chk("midrst_prdata", bus2.prdata, 8'h00);
    chk("midrst_pslverr", bus2.pslverr, 1'b0);
    psel = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    pen = 1'b1;
    @(negedge clk);
    #1 chk("midrst_pen_only", bus2.pready, 1'b0);
    psel = 1'b1;
    @(negedge clk);
    #1 chk("midrst_idle_access", bus2.pready, 1'b0);
    @(negedge clk);
    #1 chk("midrst_idle_access2", bus2.pready, 1'b0);
    go_idle();
    check_read("midrst_reg5", 2, 4'd5, 8'h00);
    check_read("midrst_reg6", 2, 4'd6, 8'h00);

    // Reset during a read completion forces outputs low at once.
    xfer(0, 1'b1, 4'd3, 8'hA5, rd, err, lat);
    xfer(0, 1'b0, 4'd3, 8'h00, rd, err, lat);
    chk("cplrst_rd_before", prdata_m, 8'hA5);
    chk("cplrst_pready_before", pready_m, 1'b1);
    #1 rst = 1'b0;
    #1;
    chk("cplrst_pready", bus0.pready, 1'b0);
    chk("cplrst_prdata", bus0.prdata, 8'h00);
    psel = 1'b0; pen = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    check_read("cplrst_reg3", 0, 4'd3, 8'h00);

    go_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_slave_regbank.md
Name: apb_slave_regbank

Overview:
- APB completer stage that sits directly downstream of the APB requester FSM.
- Consumes pselx, penable, pwrite, paddr and pwdata, and returns pready, prdata and pslverr.
- Holds a small bank of read/write registers and inserts a parameterised number of wait states per transfer.
- Flags out-of-range addresses with pslverr.

Parameters:
- ADDR_WIDTH, 4: width of paddr.
- DATA_WIDTH, 8: width of pwdata, prdata and each register.
- NUM_REGS, 8: number of implemented registers, at addresses 0..NUM_REGS-1. Must be ≤ 2^ADDR_WIDTH.
- WAIT_CYCLES, 1: wait states inserted in ACCESS before pready; 0..15.

Ports:
- clk, input, 1: single clock, all state updates on rising edge.
- rst, input, 1: asynchronous active-low reset.
- pselx, input, 1: slave select from the requester.
- penable, input, 1: access phase strobe.
- pwrite, input, 1: 1 = write, 0 = read.
- paddr, input, ADDR_WIDTH: register address.
- pwdata, input, DATA_WIDTH: write data.
- prdata, output, DATA_WIDTH: read data, valid only while pready=1 and the transfer is a read.
- pready, output, 1: transfer completes on the cycle pready=1.
- pslverr, output, 1: error response, valid only while pready=1.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, wait counter=0, all registers=0, latched addr/data/write=0. Outputs pready=0, prdata=0, pslverr=0. Reset is applied immediately, mid-transfer included; any in-flight write is dropped.
- States: IDLE, ACCESS.
- IDLE:
  - pselx=1 & penable=0 (setup phase): latch paddr, pwdata and pwrite; load wait counter with WAIT_CYCLES; next state ACCESS.
  - Otherwise stay in IDLE.
  - penable=1 without a prior setup is ignored: stay IDLE, pready=0.
- ACCESS, with pselx=1 & penable=1:
  - Counter ≠ 0: decrement by 1, pready=0, stay in ACCESS.
  - Counter = 0: pready=1 (combinational from state and counter); next state IDLE.
- ACCESS, with pselx=0: abort. Next state IDLE, no register write, pready=0.
- ACCESS, with pselx=1 & penable=0: treat as a new setup. Re-latch address, data and write; reload the counter; stay in ACCESS; the previous transfer is discarded.
- Completion cycle (pready=1):
  - Latched addr < NUM_REGS, write: reg[addr] ← latched pwdata at that clock edge. pslverr=0, prdata=0.
  - Latched addr < NUM_REGS, read: prdata = reg[addr]. pslverr=0.
  - Latched addr ≥ NUM_REGS: pslverr=1, prdata=0, and no register changes.
- Outside completion cycles: prdata=0 and pslverr=0.
- Latency, counting from the setup cycle T0:
  - pready rises in cycle T0+1+WAIT_CYCLES.
  - Zero-wait (WAIT_CYCLES=0): completes in T0+1.
- Back-to-back transfers: after completion the FSM is in IDLE, so a requester setup in the very next cycle is accepted. No dead cycle is required.
- paddr/pwdata changes during ACCESS have no effect, because the latched values are used.
- Register width is exactly DATA_WIDTH; writes have no truncation or sign behaviour.

Test Plan:
- Reset: hold rst=0 for 3 cycles with pselx=1 → pready=0, prdata=0, pslverr=0. Read all 8 registers after release → each returns 0x00.
- Write then read (WAIT_CYCLES=1): setup addr=3, pwdata=0xA5, pwrite=1 at T0 → pready=0 at T1, pready=1 at T2, reg3=0xA5 after T2. Read addr=3 → prdata=0xA5 with pready=1 at T+2.
- Zero-wait build (WAIT_CYCLES=0): back-to-back writes to addr 1 (0x11) and addr 2 (0x22) in consecutive setup/access pairs → each pready=1 one cycle after its setup. Readbacks give 0x11 and 0x22.
- Out-of-range: write addr=9 (NUM_REGS=8), pwdata=0xFF → pslverr=1 with pready=1, prdata=0, all registers unchanged. Read addr=15 → pslverr=1, prdata=0.
- Abort: setup write addr=4, 0x3C, then drop pselx during the wait state → pready never asserts, and reg4 stays at its previous value (0x00).
- Reset mid-transfer (WAIT_CYCLES=3): write addr=5, 0x77, and assert rst=0 during the second wait cycle → outputs go to 0 immediately, reg5=0x00 after release, FSM in IDLE (penable=1 alone gives pready=0).
